// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative HI/LO multiply/divide unit.
// Holds the op encodings, FSM state type and iteration count.
package mul_div_unit_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam int ITER  = 32;
  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } mdu_state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply / 32/32 divide producing HI/LO results.
// One radix-2 step per cycle on a single 65-bit shared accumulator.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter logic [31:0] DIV0_LO = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output mdu_state_e  stateDbg
);

  // Handshake: start is sampled only in IDLE (busy=0); busy stays high from
  // the cycle after acceptance through DONE; done/hi_we/lo_we pulse for the
  // single DONE cycle, when hi_out/lo_out carry the result.

  mdu_state_e        state, nextState;
  logic [1:0]        opReg;
  logic [31:0]       aReg;
  logic              bZero;
  logic              negA, negB;
  logic [32:0]       magB;
  logic [64:0]       acc;
  logic [CNT_W-1:0]  cnt;
  logic              fixStage;

  logic              inSigned, inNegA, inNegB;
  logic [32:0]       inMagA, inMagB;
  logic              isDiv;
  logic [32:0]       mulSum;
  logic [64:0]       mulNext;
  logic [64:0]       divShift;
  logic [32:0]       divTrial;
  logic [64:0]       divNext;
  logic [63:0]       prodFix;
  logic [31:0]       quotFix, remFix;
  logic [63:0]       fixed;

  // Magnitudes are 33 bits so that -2^31 converts to +2^31 without overflow.
  always_comb begin
    inSigned = (op == OP_MULT) || (op == OP_DIV);
    inNegA   = inSigned && a[31];
    inNegB   = inSigned && b[31];
    inMagA   = inNegA ? (33'd0 - {a[31], a}) : {1'b0, a};
    inMagB   = inNegB ? (33'd0 - {b[31], b}) : {1'b0, b};
  end

  always_comb begin
    isDiv    = (opReg == OP_DIV) || (opReg == OP_DIVU);
    mulSum   = {1'b0, acc[63:32]} + (acc[0] ? magB : 33'd0);
    mulNext  = {1'b0, mulSum, acc[31:1]};
    divShift = {acc[63:0], 1'b0};
    divTrial = divShift[64:32] - magB;
    divNext  = (divShift[64:32] >= magB) ? {divTrial, divShift[31:1], 1'b1} : divShift;
  end

  // Sign correction: quotient truncates toward zero, remainder follows dividend.
  always_comb begin
    prodFix = (negA ^ negB) ? (64'd0 - acc[63:0]) : acc[63:0];
    quotFix = (negA ^ negB) ? (32'd0 - acc[31:0]) : acc[31:0];
    remFix  = negA ? (32'd0 - acc[63:32]) : acc[63:32];
    fixed   = prodFix;
    if (isDiv) begin
      fixed = bZero ? {aReg, DIV0_LO} : {remFix, quotFix};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE: if (start) nextState = ST_CALC;
      ST_CALC: if (cnt == CNT_W'(ITER - 1)) nextState = ST_FIX;
      ST_FIX:  if (fixStage) nextState = ST_DONE;
      ST_DONE: nextState = ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
  end

  // FIX takes two cycles: apply sign correction, then publish to HI/LO outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opReg    <= OP_MULT;
      aReg     <= '0;
      bZero    <= 1'b0;
      negA     <= 1'b0;
      negB     <= 1'b0;
      magB     <= '0;
      acc      <= '0;
      cnt      <= '0;
      fixStage <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            opReg    <= op;
            aReg     <= a;
            bZero    <= (b == 32'd0);
            negA     <= inNegA;
            negB     <= inNegB;
            magB     <= inMagB;
            acc      <= {32'd0, inMagA};
            cnt      <= '0;
            fixStage <= 1'b0;
          end
        end
        ST_CALC: begin
          acc <= isDiv ? divNext : mulNext;
          cnt <= cnt + 1'b1;
        end
        ST_FIX: begin
          if (!fixStage) begin
            acc      <= {1'b0, fixed};
            fixStage <= 1'b1;
          end else begin
            hi_out <= acc[63:32];
            lo_out <= acc[31:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign hi_we    = done;
  assign lo_we    = done;
  assign stateDbg = state;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed HI/LO vectors, random ops
// against a behavioural model, busy/DONE start filtering and reset abort.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, hi_we, lo_we;
  logic [31:0] hi_out, lo_out;
  mdu_state_e  state_dbg;

  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  int          n_checks = 0;
  int          n_pass = 0;
  int          done_count = 0;
  int          done_before;
  logic [1:0]  r_op;
  logic [31:0] r_a, r_b;

  mul_div_unit #(.DIV0_LO(32'hFFFFFFFF)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi_we(hi_we), .lo_we(lo_we),
    .hi_out(hi_out), .lo_out(lo_out), .stateDbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
  endtask

  function automatic logic [63:0] model(input logic [1:0] mop, input logic [31:0] ma,
                                        input logic [31:0] mb);
    longint sa, sb, sp, q, rm;
    logic [63:0] r;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    r  = '0;
    case (mop)
      OP_MULT:  begin sp = sa * sb; r = sp; end
      OP_MULTU: r = {32'd0, ma} * {32'd0, mb};
      OP_DIV: begin
        if (mb == 32'd0) r = {ma, 32'hFFFFFFFF};
        else begin q = sa / sb; rm = sa % sb; r = {rm[31:0], q[31:0]}; end
      end
      default: begin
        if (mb == 32'd0) r = {ma, 32'hFFFFFFFF};
        else r = {ma % mb, ma / mb};
      end
    endcase
    return r;
  endfunction

  // Scoreboard: every done pulse pops one expected {HI, LO}.
  always @(negedge clk) begin
    if (done) begin
      done_count++;
      check("hi_we", {31'd0, hi_we}, 32'd1);
      check("lo_we", {31'd0, lo_we}, 32'd1);
      if (exp_q.size() == 0) begin
        check("spurious_done", {31'd0, done}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("hi_out", hi_out, mon_e[63:32]);
        check("lo_out", lo_out, mon_e[31:0]);
      end
    end
  end

  // Called just after a negedge with busy=0. glitch_at>0 pulses a foreign start
  // sampled at edge T+glitch_at; start_in_done raises start during DONE.
  task automatic do_op(input logic [1:0] o, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [63:0] e, input int glitch_at, input bit start_in_done);
    int lat;
    bit seen;
    op = o; a = ia; b = ib; start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      #1 start = 1'b0;
      lat++;
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (lat == glitch_at - 1) begin
        check("busy_mid", {31'd0, busy}, 32'd1);
        op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom; start = 1'b1;
      end
    end
    check("latency", 32'(lat), 32'd34);
    if (!seen) exp_q.delete();
    if (start_in_done && seen) begin
      op = OP_MULTU; a = 32'd3; b = 32'd3; start = 1'b1;
    end
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd0);
    check("busy_after", {31'd0, busy}, 32'd0);
  endtask

  task automatic reset_abort();
    op = OP_MULTU; a = $urandom; b = $urandom; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_hi", hi_out, 32'd0);
    check("rst_lo", lo_out, 32'd0);
    check("rst_we", {30'd0, hi_we, lo_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_before = done_count;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("no_done_after_rst", 32'(done_count - done_before), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = OP_MULT; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_we", {30'd0, hi_we, lo_we}, 32'd0);
    check("reset_hi", hi_out, 32'd0);
    check("reset_lo", lo_out, 32'd0);
    check("reset_state", 32'(state_dbg), 32'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);

    do_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'h00000001}, 0, 1'b0);
    do_op(OP_MULT,  32'hFFFFFFFD, 32'd5,        {32'hFFFFFFFF, 32'hFFFFFFF1}, 0, 1'b0);
    do_op(OP_DIV,   32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 0, 1'b0);
    do_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 0, 1'b0);
    do_op(OP_DIVU,  32'd100,      32'd0,        {32'h00000064, 32'hFFFFFFFF}, 0, 1'b0);
    do_op(OP_DIVU,  32'd100,      32'd7,        {32'd2, 32'd14}, 5, 1'b0);
    do_op(OP_DIV,   32'hFFFFFFFB, 32'd0,        {32'hFFFFFFFB, 32'hFFFFFFFF}, 0, 1'b1);
    do_op(OP_MULT,  32'h80000000, 32'h80000000, {32'h40000000, 32'h00000000}, 0, 1'b0);
    do_op(OP_DIV,   32'd7,        32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
      r_b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if (i == 3) r_b = $urandom_range(1, 300);
      do_op(r_op, r_a, r_b, model(r_op, r_a, r_b), 0, 1'b0);
    end

    reset_abort();
    do_op(OP_MULTU, 32'd6, 32'd7, {32'd0, 32'd42}, 0, 1'b0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
